// File: rtl/memory_bus_arbiter.sv
// Two-requester memory bus arbiter (fetch vs. exec) running one access at a time with fixed wait states.
// Optional macro ARB_ROUND_ROBIN_EN switches contention handling from exec-priority to alternating.
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_wdata,
  output logic                  exec_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_exec,
  output logic [2:0]            debug_state
);
  localparam int WS_EFF = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
  localparam int CW     = (WS_EFF > 1) ? $clog2(WS_EFF) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_write;
  logic          last_grant; // 1 = exec was granted last
  logic          win_exec;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention hand the bus to whoever did not get it last time.
  assign win_exec = exec_req && (!fetch_req || !last_grant);
`else
  assign win_exec = exec_req;
`endif

  assign debug_state = {last_grant, state};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      is_write   <= 1'b0;
      last_grant <= 1'b0;
      fetch_ack  <= 1'b0;
      exec_ack   <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      grant_exec <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      exec_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || exec_req) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            grant_exec <= win_exec;
            last_grant <= win_exec;
            cnt        <= CW'(WS_EFF - 1);
            if (win_exec) begin
              mem_addr  <= exec_addr;
              mem_wdata <= exec_wdata;
              is_write  <= exec_we;
              mem_we    <= exec_we;
              mem_re    <= !exec_we;
            end else begin
              mem_addr <= fetch_addr;
              is_write <= 1'b0;
              mem_we   <= 1'b0;
              mem_re   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (!is_write) rdata <= mem_rdata;
            if (grant_exec) exec_ack <= 1'b1;
            else            fetch_ack <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // Requests are not sampled here; a held request is picked up in the next IDLE cycle.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: one instance with WAIT_STATES=1, one with WAIT_STATES=3.
module tb_memory_bus_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        fetch_req[2], exec_req[2], exec_we[2];
  logic [15:0] fetch_addr[2], exec_addr[2];
  logic [7:0]  exec_wdata[2], mem_rdata[2];
  logic        fetch_ack[2], exec_ack[2], mem_re[2], mem_we[2], busy[2], grant_exec[2];
  logic [7:0]  rdata[2], mem_wdata[2];
  logic [15:0] mem_addr[2];
  logic [2:0]  debug_state[2];

  memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(1)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]), .fetch_ack(fetch_ack[0]),
    .exec_req(exec_req[0]), .exec_we(exec_we[0]), .exec_addr(exec_addr[0]),
    .exec_wdata(exec_wdata[0]), .exec_ack(exec_ack[0]), .rdata(rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_re(mem_re[0]), .mem_we(mem_we[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .grant_exec(grant_exec[0]),
    .debug_state(debug_state[0])
  );

  memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(3)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]), .fetch_ack(fetch_ack[1]),
    .exec_req(exec_req[1]), .exec_we(exec_we[1]), .exec_addr(exec_addr[1]),
    .exec_wdata(exec_wdata[1]), .exec_ack(exec_ack[1]), .rdata(rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_re(mem_re[1]), .mem_we(mem_we[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .grant_exec(grant_exec[1]),
    .debug_state(debug_state[1])
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         d;
    bit         ex;
    bit         we;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  mv;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_wd;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      fetch_req[i] = 1'b0; exec_req[i] = 1'b0; exec_we[i] = 1'b0;
      fetch_addr[i] = '0; exec_addr[i] = '0; exec_wdata[i] = '0; mem_rdata[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic check_quiet(input int d, input string tag);
    check({tag, "_ctl"}, {fetch_ack[d], exec_ack[d], mem_re[d], mem_we[d], busy[d]}, 0);
    check({tag, "_state"}, {30'd0, debug_state[d][1:0]}, 0);
  endtask

  // Single access: raise req, watch strobes each cycle, expect ack WS cycles after first strobe.
  task automatic run_one(input vec_t v);
    int  ws, cyc, first_cyc, ack_cyc, strobe_n;
    bit  got_ack, bad_strobe, wrong_ack;
    bit  exp_re, exp_we;
    ws = (v.d == 1) ? 3 : 1;
    exp_we = v.ex && v.we;
    exp_re = !exp_we;
    cyc = 0; first_cyc = -1; ack_cyc = -1; strobe_n = 0;
    got_ack = 0; bad_strobe = 0; wrong_ack = 0;
    mem_rdata[v.d] = v.mv;
    if (v.ex) begin
      exec_req[v.d] = 1'b1; exec_we[v.d] = v.we;
      exec_addr[v.d] = v.a; exec_wdata[v.d] = v.wd;
    end else begin
      fetch_req[v.d] = 1'b1; fetch_addr[v.d] = v.a;
    end
    while (!got_ack && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (mem_re[v.d] || mem_we[v.d]) begin
        if (first_cyc < 0) first_cyc = cyc;
        strobe_n++;
        if (mem_re[v.d] !== exp_re || mem_we[v.d] !== exp_we ||
            mem_addr[v.d] !== v.a || mem_wdata[v.d] !== v.exp_wd)
          bad_strobe = 1;
      end
      if (v.ex ? fetch_ack[v.d] : exec_ack[v.d]) wrong_ack = 1;
      if (v.ex ? exec_ack[v.d] : fetch_ack[v.d]) begin
        got_ack = 1;
        ack_cyc = cyc;
      end
    end
    fetch_req[v.d] = 1'b0;
    exec_req[v.d]  = 1'b0;
    check("ack_seen", {31'd0, got_ack}, 1);
    check("grant_lat", first_cyc, 1);
    check("strobe_len", strobe_n, ws);
    check("strobe_sig", {31'd0, bad_strobe}, 0);
    check("ack_lat", ack_cyc - first_cyc, ws);
    check("wrong_ack", {31'd0, wrong_ack}, 0);
    check("rdata", {24'd0, rdata[v.d]}, {24'd0, v.exp_rd});
    check("grant_exec", {31'd0, grant_exec[v.d]}, {31'd0, v.ex});
    @(negedge clock);
    check_quiet(v.d, "post_ack");
  endtask

  initial begin
    int  cyc, n_ack, first_s, second_s, s_total;
    bit  overlap, prev_s, seen_ack;
    logic [3:0] order;
    logic [3:0] exp_order;

    tbl[0] = '{0, 1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 8'hA5, 8'h00};
    tbl[1] = '{1, 1'b1, 1'b0, 16'h0123, 8'h12, 8'h5E, 8'h5E, 8'h12};
    tbl[2] = '{1, 1'b1, 1'b1, 16'h0200, 8'h3C, 8'h77, 8'h5E, 8'h3C};
    tbl[3] = '{1, 1'b0, 1'b0, 16'hFFFF, 8'hEE, 8'hC3, 8'hC3, 8'h3C};
    tbl[4] = '{0, 1'b1, 1'b1, 16'h0011, 8'h99, 8'h11, 8'hA5, 8'h99};
    tbl[5] = '{0, 1'b1, 1'b0, 16'h8000, 8'h44, 8'h00, 8'h00, 8'h44};
    tbl[6] = '{0, 1'b0, 1'b0, 16'h0001, 8'h21, 8'hFF, 8'hFF, 8'h44};

    // Reset and idle state.
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check_quiet(d, "reset");
      check("reset_data", {rdata[d], mem_wdata[d], mem_addr[d]}, 0);
      check("reset_grant", {29'd0, grant_exec[d], debug_state[d][2]}, 0);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) check_quiet(d, "idle");

    for (int i = 0; i < 7; i++) run_one(tbl[i]);

    // Simultaneous requests, each dropped on its own ack.
    do_reset();
    fetch_req[0] = 1'b1; fetch_addr[0] = 16'h0AAA;
    exec_req[0] = 1'b1; exec_we[0] = 1'b0; exec_addr[0] = 16'h0BBB;
    n_ack = 0; overlap = 0; order = '0; cyc = 0;
    while (n_ack < 2 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (fetch_ack[0] && exec_ack[0]) overlap = 1;
      if (exec_ack[0] || fetch_ack[0]) begin
        order[n_ack] = exec_ack[0];
        n_ack++;
        if (exec_ack[0]) exec_req[0] = 1'b0;
        if (fetch_ack[0]) fetch_req[0] = 1'b0;
      end
    end
    clear_inputs();
    check("cont_acks", n_ack, 2);
    check("cont_first_exec", {31'd0, order[0]}, 1);
    check("cont_second_fetch", {31'd0, order[1]}, 0);
    check("cont_overlap", {31'd0, overlap}, 0);

    // Both requests held for four accesses.
    do_reset();
    fetch_req[0] = 1'b1; fetch_addr[0] = 16'h0100;
    exec_req[0] = 1'b1; exec_we[0] = 1'b0; exec_addr[0] = 16'h0200;
    n_ack = 0; overlap = 0; order = '0; cyc = 0;
    while (n_ack < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (fetch_ack[0] && exec_ack[0]) overlap = 1;
      if (exec_ack[0] || fetch_ack[0]) begin
        order[3 - n_ack] = exec_ack[0];
        n_ack++;
      end
    end
    clear_inputs();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    check("hold_acks", n_ack, 4);
    check("hold_order", {28'd0, order}, {28'd0, exp_order});
    check("hold_overlap", {31'd0, overlap}, 0);

    // Fetch held after ack on the WAIT_STATES=3 instance: second access WS+2 cycles later.
    do_reset();
    fetch_req[1] = 1'b1; fetch_addr[1] = 16'h0042; mem_rdata[1] = 8'h6B;
    n_ack = 0; cyc = 0; first_s = -1; second_s = -1; s_total = 0; prev_s = 0; overlap = 0;
    while (n_ack < 2 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (mem_re[1]) begin
        s_total++;
        if (mem_addr[1] !== 16'h0042 || mem_we[1]) overlap = 1;
        if (!prev_s) begin
          if (first_s < 0) first_s = cyc;
          else second_s = cyc;
        end
      end
      prev_s = mem_re[1];
      if (fetch_ack[1]) n_ack++;
      if (n_ack == 2) fetch_req[1] = 1'b0;
    end
    clear_inputs();
    check("b2b_acks", n_ack, 2);
    check("b2b_gap", second_s - first_s, 5);
    check("b2b_strobes", s_total, 6);
    check("b2b_sig", {31'd0, overlap}, 0);
    check("b2b_rdata", {24'd0, rdata[1]}, 32'h6B);

    // Reset in the middle of a write aborts it.
    do_reset();
    exec_req[1] = 1'b1; exec_we[1] = 1'b1; exec_addr[1] = 16'h0300; exec_wdata[1] = 8'h5A;
    repeat (2) @(negedge clock);
    check("mid_we_active", {31'd0, mem_we[1]}, 1);
    reset_n = 1'b0;
    #1;
    check("mid_abort", {29'd0, mem_we[1], mem_re[1], busy[1]}, 0);
    check("mid_state", {30'd0, debug_state[1][1:0]}, 0);
    seen_ack = 0;
    exec_req[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k == 1) reset_n = 1'b1;
      if (exec_ack[1] || fetch_ack[1]) seen_ack = 1;
    end
    check("mid_no_ack", {31'd0, seen_ack}, 0);
    check_quiet(1, "mid_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
